split_stream_checker: RTL and testbench

Sequential, parametrised successor to the constant-true split constraint block. Takes the variable assignment of one split as a stream of beats, one beat per variable, in index order. It checks each value against its declared bit width and a per-variable upper bound, then returns a single satisfied/unsatisfied verdict through a valid/ready handshake. It sits between the solver's assignment generator and the split-result collector.

---
 rtl/split_stream_checker.sv | 77 +++++++
 tb/tb_split_stream_checker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/split_stream_checker.sv
// split_stream_checker: checks one split's variable stream (width, bound, index order) and returns a verdict.
// Optional `SPLIT_FAIL_CNT_EN adds out_fail_cnt, the number of failed beats in the frame.
module split_stream_checker #(
  parameter int NUM_VARS = 150,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 8,
  parameter int WID_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WID_W-1:0]  in_width,
  input  logic [DATA_W-1:0] in_bound,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_x,
  output logic              out_err,
  output logic [IDX_W-1:0]  out_fail_idx,
  output logic              busy
`ifdef SPLIT_FAIL_CNT_EN
  ,
  output logic [IDX_W:0]    out_fail_cnt
`endif
);
  localparam int CW = IDX_W + 1;
  typedef enum logic [1:0] {IDLE, COLLECT, RESULT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic sat, err;
  logic [IDX_W-1:0] fail_idx;
  logic acc, width_bad, order_bad, beat_fail, last;
  always_comb begin
    acc       = state == COLLECT && in_valid;
    width_bad = in_width == '0 || in_width > WID_W'(DATA_W);
    order_bad = {1'b0, in_idx} != cnt;
    beat_fail = width_bad || (in_data >> in_width) != '0 || in_data > in_bound || order_bad;
    last      = cnt == CW'(NUM_VARS - 1);
    state_nx  = state == IDLE    ? (start ? COLLECT : IDLE) :
                state == COLLECT ? (acc && last ? RESULT : COLLECT) :
                                   (out_ready ? IDLE : RESULT);
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // sat doubles as the "no failure yet" flag, so fail_idx latches only once
  always_ff @(posedge clk)
    if (!rst_n || (state == IDLE && start)) begin
      cnt      <= '0;
      sat      <= 1'b1;
      err      <= 1'b0;
      fail_idx <= '0;
    end else if (acc) begin
      cnt <= cnt + 1'b1;
      if (order_bad || width_bad) err <= 1'b1;
      if (beat_fail) begin
        sat <= 1'b0;
        if (sat) fail_idx <= cnt[IDX_W-1:0];
      end
    end
`ifdef SPLIT_FAIL_CNT_EN
  logic [CW-1:0] fail_cnt;
  always_ff @(posedge clk)
    if (!rst_n || (state == IDLE && start)) fail_cnt <= '0;
    else if (acc && beat_fail && fail_cnt != CW'(NUM_VARS)) fail_cnt <= fail_cnt + 1'b1;
  assign out_fail_cnt = fail_cnt;
`endif
  assign in_ready     = state == COLLECT;
  assign out_valid    = state == RESULT;
  assign busy         = state != IDLE;
  assign out_x        = sat && !err;
  assign out_err      = err;
  assign out_fail_idx = fail_idx;
endmodule

// File: tb/tb_split_stream_checker.sv
// tb_split_stream_checker: table-driven, hand-written and random frames against a spec-level model.
module tb_split_stream_checker;
  localparam int N = 150;
  logic clk = 0, rst_n = 0, start = 0, start1 = 0, in_valid = 0, out_ready = 0, out_ready1 = 0;
  logic [7:0] in_idx = 0;
  logic [15:0] in_data = 0, in_bound = 0;
  logic [4:0] in_width = 0;
  logic in_ready, out_valid, out_x, out_err, busy;
  logic in_ready1, out_valid1, out_x1, out_err1, busy1;
  logic [7:0] out_fail_idx, out_fail_idx1;
`ifdef SPLIT_FAIL_CNT_EN
  logic [8:0] out_fail_cnt, out_fail_cnt1;
`endif
  int total = 0, bad = 0;
  logic [7:0] b_idx[N];
  logic [15:0] b_data[N], b_bound[N];
  logic [4:0] b_width[N];

  always #5 clk = ~clk;

  split_stream_checker #(.NUM_VARS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_data(in_data), .in_width(in_width), .in_bound(in_bound),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_err(out_err),
    .out_fail_idx(out_fail_idx), .busy(busy)
`ifdef SPLIT_FAIL_CNT_EN
    , .out_fail_cnt(out_fail_cnt)
`endif
  );

  split_stream_checker #(.NUM_VARS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_ready(in_ready1),
    .in_idx(in_idx), .in_data(in_data), .in_width(in_width), .in_bound(in_bound),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_x(out_x1), .out_err(out_err1),
    .out_fail_idx(out_fail_idx1), .busy(busy1)
`ifdef SPLIT_FAIL_CNT_EN
    , .out_fail_cnt(out_fail_cnt1)
`endif
  );

  typedef struct {
    int p0; logic [7:0] i0; logic [15:0] d0; logic [4:0] w0; logic [15:0] bd0;
    int p1; logic [7:0] i1; logic [15:0] d1; logic [4:0] w1; logic [15:0] bd1;
    logic ex; logic ee; logic [7:0] efi; int efc;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_good();
    for (int i = 0; i < N; i++) begin
      b_idx[i] = 8'(i); b_data[i] = 3; b_width[i] = 4; b_bound[i] = 10;
    end
  endtask

  task automatic send_beats(input int a, input int b, input bit gaps, input bit noise);
    for (int i = a; i <= b; i++) begin
      for (int g = 0; gaps && g < 3 && $urandom_range(3) == 0; g++) begin
        in_valid = 0; in_data = 16'($urandom); start = noise; tick();
      end
      start = noise & 1'($urandom_range(1));
      in_valid = 1; in_idx = b_idx[i]; in_data = b_data[i]; in_width = b_width[i]; in_bound = b_bound[i];
      tick();
    end
    in_valid = 0; start = 0;
  endtask

  task automatic run_frame(input bit gaps, input bit noise);
    start = 1; tick(); start = 0;
    send_beats(0, N - 1, gaps, noise);
  endtask

  task automatic check_verdict(input string t, input logic ex, input logic ee, input logic [7:0] efi, input int efc);
    chk({t, ".valid"}, out_valid, 1);
    chk({t, ".x"}, out_x, ex);
    chk({t, ".err"}, out_err, ee);
    chk({t, ".fidx"}, out_fail_idx, efi);
`ifdef SPLIT_FAIL_CNT_EN
    chk({t, ".fcnt"}, out_fail_cnt, efc);
`endif
  endtask

  task automatic handshake(input string t);
    out_ready = 1; tick(); out_ready = 0;
    chk({t, ".valid_drop"}, out_valid, 0);
    chk({t, ".busy_drop"}, busy, 0);
  endtask

  task automatic check_reset(input string t);
    chk({t, ".in_ready"}, in_ready, 0);
    chk({t, ".valid"}, out_valid, 0);
    chk({t, ".x"}, out_x, 1);
    chk({t, ".err"}, out_err, 0);
    chk({t, ".fidx"}, out_fail_idx, 0);
    chk({t, ".busy"}, busy, 0);
`ifdef SPLIT_FAIL_CNT_EN
    chk({t, ".fcnt"}, out_fail_cnt, 0);
`endif
  endtask

  // verdict computed straight from the beat rules over the whole frame
  task automatic model(output logic x, output logic e, output logic [7:0] fi, output int fc);
    logic s = 1;
    e = 0; fi = 0; fc = 0;
    for (int i = 0; i < N; i++) begin
      int w = int'(b_width[i]);
      bit bw = w == 0 || w > 16;
      bit bo = int'(b_idx[i]) != i;
      bit f = bw || bo || int'(b_data[i]) >= (1 << w) || b_data[i] > b_bound[i];
      if (bw || bo) e = 1;
      if (f) begin
        if (s) fi = 8'(i);
        s = 0;
        fc++;
      end
    end
    x = s && !e;
  endtask

  task automatic gen_random(input int rate);
    for (int i = 0; i < N; i++) begin
      int w = $urandom_range(16, 1);
      int d = int'($urandom) & ((1 << w) - 1);
      b_idx[i] = 8'(i); b_width[i] = 5'(w); b_data[i] = 16'(d);
      b_bound[i] = 16'($urandom_range(65535, d));
      if ($urandom_range(rate) == 0)
        case ($urandom_range(3))
          0: b_width[i] = $urandom_range(1) ? 5'd0 : 5'($urandom_range(31, 17));
          1: b_data[i] = w < 16 ? b_data[i] | 16'(1 << w) : b_data[i];
          2: b_bound[i] = d > 0 ? 16'(d - 1) : b_bound[i];
          default: b_idx[i] = 8'(i + 1);
        endcase
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic mx, me;
    logic [7:0] mfi;
    int mfc;
    vecs[0] = '{-1, 0, 0, 0, 0, -1, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[1] = '{37, 37, 16'h0010, 4, 10, 90, 90, 12, 4, 10, 0, 0, 37, 2};
    vecs[2] = '{5, 6, 3, 4, 10, -1, 0, 0, 0, 0, 0, 1, 5, 1};
    vecs[3] = '{0, 0, 3, 0, 10, -1, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[4] = '{0, 0, 3, 17, 10, -1, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[5] = '{149, 149, 11, 4, 10, -1, 0, 0, 0, 0, 0, 0, 149, 1};
    vecs[6] = '{0, 0, 10, 4, 10, 1, 1, 15, 4, 15, 1, 0, 0, 0};
    vecs[7] = '{0, 0, 16'hFFFF, 16, 16'hFFFF, 2, 2, 16'h001F, 4, 16'hFFFF, 0, 0, 2, 1};

    tick(); tick();
    check_reset("reset");
    rst_n = 1; tick();

    foreach (vecs[k]) begin
      fill_good();
      if (vecs[k].p0 >= 0) begin
        b_idx[vecs[k].p0] = vecs[k].i0; b_data[vecs[k].p0] = vecs[k].d0;
        b_width[vecs[k].p0] = vecs[k].w0; b_bound[vecs[k].p0] = vecs[k].bd0;
      end
      if (vecs[k].p1 >= 0) begin
        b_idx[vecs[k].p1] = vecs[k].i1; b_data[vecs[k].p1] = vecs[k].d1;
        b_width[vecs[k].p1] = vecs[k].w1; b_bound[vecs[k].p1] = vecs[k].bd1;
      end
      run_frame(0, 0);
      check_verdict($sformatf("vec%0d", k), vecs[k].ex, vecs[k].ee, vecs[k].efi, vecs[k].efc);
      handshake($sformatf("vec%0d", k));
    end

    // verdict held under back-pressure with start pulsing; handshake+start goes to IDLE only
    fill_good();
    b_data[37] = 16'h0010; b_data[90] = 12;
    run_frame(0, 0);
    check_verdict("hold", 0, 0, 37, 2);
    for (int c = 0; c < 10; c++) begin
      start = c[0]; tick();
      chk("hold.valid", out_valid, 1);
      chk("hold.x", out_x, 0);
      chk("hold.fidx", out_fail_idx, 37);
      chk("hold.busy", busy, 1);
    end
    start = 1; out_ready = 1; tick(); start = 0; out_ready = 0;
    chk("hold.valid_drop", out_valid, 0);
    chk("hold.in_ready", in_ready, 0);
    tick();
    chk("hold.no_restart", busy, 0);
    chk("hold.x_kept", out_x, 0);
    chk("hold.fidx_kept", out_fail_idx, 37);

    // reset mid-frame aborts with no verdict
    fill_good();
    b_data[3] = 16'h0010;
    start = 1; tick(); start = 0;
    send_beats(0, 69, 0, 0);
    chk("abort.busy", busy, 1);
    rst_n = 0; tick();
    check_reset("abort");
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort.no_verdict", out_valid, 0);
    end
    fill_good();
    run_frame(0, 0);
    check_verdict("after_abort", 1, 0, 0, 0);
    handshake("after_abort");

    for (int r = 0; r < 8; r++) begin
      gen_random(r < 2 ? 1000 : 20 * r);
      model(mx, me, mfi, mfc);
      run_frame(1, 1);
      check_verdict($sformatf("rand%0d", r), mx, me, mfi, mfc);
      handshake($sformatf("rand%0d", r));
    end

    // NUM_VARS=1 instance: single full-range beat, then a bound miss
    for (int r = 0; r < 2; r++) begin
      start1 = 1; tick(); start1 = 0;
      in_valid = 1; in_idx = 0; in_data = 16'hFFFF; in_width = 16; in_bound = r == 0 ? 16'hFFFF : 16'hFFFE;
      tick(); in_valid = 0;
      chk("nv1.valid", out_valid1, 1);
      chk("nv1.in_ready", in_ready1, 0);
      chk("nv1.x", out_x1, r == 0);
      chk("nv1.err", out_err1, 0);
      chk("nv1.fidx", out_fail_idx1, 0);
      out_ready1 = 1; tick(); out_ready1 = 0;
      chk("nv1.valid_drop", out_valid1, 0);
      chk("nv1.busy", busy1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
